// File: rtl/id_ex_if.sv
// Decode-to-execute bus: upstream decoded instruction, later-stage forwarding
// sources, and the registered ALU-side outputs of the ID/EX stage.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  // Upstream decoded instruction
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs1_addr;
  logic [REG_AW-1:0] in_rs2_addr;
  logic [DATA_W-1:0] in_rs1_data;
  logic [DATA_W-1:0] in_rs2_data;
  logic [DATA_W-1:0] in_imm;
  logic              in_use_imm;
  logic [3:0]        in_alu_ctrl;
  logic [REG_AW-1:0] in_rd_addr;
  logic              in_rd_we;
  logic              in_is_load;
  logic              flush;

  // Forwarding sources from EX, MEM and WB
  logic [DATA_W-1:0] ex_result;
  logic [REG_AW-1:0] mem_rd_addr;
  logic              mem_rd_we;
  logic [DATA_W-1:0] mem_data;
  logic [REG_AW-1:0] wb_rd_addr;
  logic              wb_rd_we;
  logic [DATA_W-1:0] wb_data;

  // Downstream ALU side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [3:0]        alu_ctrl;
  logic [REG_AW-1:0] out_rd_addr;
  logic              out_rd_we;
  logic              out_is_load;
  logic [CNT_W-1:0]  bubble_cnt;

  // Environment side: drives the instruction and forwarding sources
  modport master (
    output in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, in_alu_ctrl, in_rd_addr, in_rd_we, in_is_load,
           flush, ex_result, mem_rd_addr, mem_rd_we, mem_data,
           wb_rd_addr, wb_rd_we, wb_data, out_ready,
    input  in_ready, out_valid, op_a, op_b, alu_ctrl, out_rd_addr,
           out_rd_we, out_is_load, bubble_cnt
  );

  // Stage side
  modport slave (
    input  in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, in_alu_ctrl, in_rd_addr, in_rd_we, in_is_load,
           flush, ex_result, mem_rd_addr, mem_rd_we, mem_data,
           wb_rd_addr, wb_rd_we, wb_data, out_ready,
    output in_ready, out_valid, op_a, op_b, alu_ctrl, out_rd_addr,
           out_rd_we, out_is_load, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Resolves RAW hazards by
// forwarding EX > MEM > WB > register file, inserts one bubble on a
// load-use hazard, and honours flush above every other event.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [3:0]        alu_ctrl;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_we;
    logic              is_load;
  } ex_reg_t;

  logic             valid_q;
  ex_reg_t          ex_q;
  ex_reg_t          ex_d;
  logic [CNT_W-1:0] cnt_q;

  logic advance;
  logic rs2_used;
  logic ex_rs1, ex_rs2, mem_rs1, mem_rs2, wb_rs1, wb_rs2;
  logic load_use;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // Handshake: the register may be overwritten when empty or draining.
  assign advance  = !valid_q || bus.out_ready;
  assign rs2_used = !bus.in_use_imm;

  // Per-source address matches. rd_we is cleared whenever valid_q is cleared,
  // so a bubble never matches; valid_q is still included for clarity.
  assign ex_rs1  = valid_q && ex_q.rd_we && (ex_q.rd_addr == bus.in_rs1_addr);
  assign ex_rs2  = valid_q && ex_q.rd_we && (ex_q.rd_addr == bus.in_rs2_addr);
  assign mem_rs1 = bus.mem_rd_we && (bus.mem_rd_addr == bus.in_rs1_addr);
  assign mem_rs2 = bus.mem_rd_we && (bus.mem_rd_addr == bus.in_rs2_addr);
  assign wb_rs1  = bus.wb_rd_we && (bus.wb_rd_addr == bus.in_rs1_addr);
  assign wb_rs2  = bus.wb_rd_we && (bus.wb_rd_addr == bus.in_rs2_addr);

  // A load in EX has no result until MEM, so a dependent consumer must wait.
  assign load_use = bus.in_valid && ex_q.is_load &&
                    (ex_rs1 || (rs2_used && ex_rs2));

  // Flush always drains the incoming instruction; otherwise accept only when
  // the register can advance and no load-use stall is pending.
  assign bus.in_ready = bus.flush || (advance && !load_use);

  // Operand A forwarding mux, youngest producer first.
  always_comb begin
    // NOTE: default first so every path assigns fwd_a and no latch is inferred.
    fwd_a = bus.in_rs1_data;
    if (ex_rs1)       fwd_a = bus.ex_result;
    else if (mem_rs1) fwd_a = bus.mem_data;
    else if (wb_rs1)  fwd_a = bus.wb_data;
  end

  // Operand B: the immediate bypasses forwarding entirely.
  always_comb begin
    fwd_b = bus.in_rs2_data;
    if (bus.in_use_imm) fwd_b = bus.in_imm;
    else if (ex_rs2)    fwd_b = bus.ex_result;
    else if (mem_rs2)   fwd_b = bus.mem_data;
    else if (wb_rs2)    fwd_b = bus.wb_data;
  end

  // Next contents of the EX register when an instruction is captured.
  always_comb begin
    ex_d          = '0;
    ex_d.op_a     = fwd_a;
    ex_d.op_b     = fwd_b;
    ex_d.alu_ctrl = bus.in_alu_ctrl;
    ex_d.rd_addr  = bus.in_rd_addr;
    ex_d.rd_we    = bus.in_rd_we;
    ex_d.is_load  = bus.in_is_load;
  end

  // EX register and bubble counter; first matching event wins.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register is reset (no memories here) so all outputs read 0
    // the moment rst rises, even with an instruction in flight.
    if (rst) begin
      // NOTE: non-blocking assignments keep all state updates simultaneous.
      valid_q <= 1'b0;
      ex_q    <= '0;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      valid_q      <= 1'b0;
      ex_q.rd_we   <= 1'b0;
      ex_q.is_load <= 1'b0;
    end else if (!advance) begin
      valid_q <= valid_q;
    end else if (load_use) begin
      valid_q      <= 1'b0;
      ex_q.rd_we   <= 1'b0;
      ex_q.is_load <= 1'b0;
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end else if (bus.in_valid) begin
      valid_q <= 1'b1;
      ex_q    <= ex_d;
    end else begin
      valid_q      <= 1'b0;
      ex_q.rd_we   <= 1'b0;
      ex_q.is_load <= 1'b0;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.op_a        = ex_q.op_a;
  assign bus.op_b        = ex_q.op_b;
  assign bus.alu_ctrl    = ex_q.alu_ctrl;
  assign bus.out_rd_addr = ex_q.rd_addr;
  assign bus.out_rd_we   = ex_q.rd_we;
  assign bus.out_is_load = ex_q.is_load;
  assign bus.bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes hand-computed expected
// ALU-side contents; a monitor pops and compares on each downstream transfer.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  ctrl;
    logic [3:0]  rd;
    logic        we;
    logic        ld;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a downstream transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("op_a",        bus.op_a,        mon_e.op_a);
        check("op_b",        bus.op_b,        mon_e.op_b);
        check("alu_ctrl",    bus.alu_ctrl,    mon_e.ctrl);
        check("out_rd_addr", bus.out_rd_addr, mon_e.rd);
        check("out_rd_we",   bus.out_rd_we,   mon_e.we);
        check("out_is_load", bus.out_is_load, mon_e.ld);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rs1, input logic [31:0] d1,
                       input logic [3:0] rs2, input logic [31:0] d2,
                       input logic use_imm, input logic [31:0] imm,
                       input logic [3:0] ctrl, input logic [3:0] rd,
                       input logic ld);
    bus.in_valid    = 1'b1;
    bus.in_rs1_addr = rs1;
    bus.in_rs1_data = d1;
    bus.in_rs2_addr = rs2;
    bus.in_rs2_data = d2;
    bus.in_use_imm  = use_imm;
    bus.in_imm      = imm;
    bus.in_alu_ctrl = ctrl;
    bus.in_rd_addr  = rd;
    bus.in_rd_we    = 1'b1;
    bus.in_is_load  = ld;
  endtask

  task automatic expect_out(input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] ctrl, input logic [3:0] rd,
                            input logic ld);
    exp_t e;
    e = '{op_a: a, op_b: b, ctrl: ctrl, rd: rd, we: 1'b1, ld: ld};
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;  bus.in_rs1_addr = '0; bus.in_rs2_addr = '0;
    bus.in_rs1_data = '0; bus.in_rs2_data = '0; bus.in_imm = '0;
    bus.in_use_imm = 1'b0; bus.in_alu_ctrl = '0; bus.in_rd_addr = '0;
    bus.in_rd_we = 1'b0;  bus.in_is_load = 1'b0; bus.flush = 1'b0;
    bus.ex_result = '0;   bus.mem_rd_addr = '0; bus.mem_rd_we = 1'b0;
    bus.mem_data = '0;    bus.wb_rd_addr = '0;  bus.wb_rd_we = 1'b0;
    bus.wb_data = '0;     bus.out_ready = 1'b1;

    #2;
    check("reset_out_valid",  bus.out_valid,  0);
    check("reset_bubble_cnt", bus.bubble_cnt, 0);
    check("reset_op_a",       bus.op_a,       0);
    step(); step();
    rst = 1'b0;

    // ADD r1 = r4 + r5, no hazards
    drive(4'd4, 32'h11, 4'd5, 32'h22, 1'b0, 32'h0, 4'd0, 4'd1, 1'b0);
    expect_out(32'h11, 32'h22, 4'd0, 4'd1, 1'b0);
    step();

    // SUB rs1=r1: EX, MEM and WB all hold r1 -> EX wins
    bus.ex_result = 32'h8;
    bus.mem_rd_addr = 4'd1; bus.mem_rd_we = 1'b1; bus.mem_data = 32'h5;
    bus.wb_rd_addr  = 4'd1; bus.wb_rd_we  = 1'b1; bus.wb_data  = 32'h3;
    drive(4'd1, 32'h0, 4'd6, 32'h7, 1'b0, 32'h0, 4'd1, 4'd7, 1'b0);
    #1 check("in_ready_fwd_ex", bus.in_ready, 1);
    expect_out(32'h8, 32'h7, 4'd1, 4'd7, 1'b0);
    step();

    // EX now holds r7 -> MEM wins
    expect_out(32'h5, 32'h7, 4'd1, 4'd7, 1'b0);
    step();

    // Only WB matches
    bus.mem_rd_we = 1'b0;
    expect_out(32'h3, 32'h7, 4'd1, 4'd7, 1'b0);
    step();
    bus.wb_rd_we = 1'b0;

    // Load r2, then AND rs2=r2 -> one bubble, then MEM forward
    drive(4'd8, 32'h100, 4'd0, 32'h0, 1'b1, 32'h4, 4'd0, 4'd2, 1'b1);
    expect_out(32'h100, 32'h4, 4'd0, 4'd2, 1'b1);
    step();
    drive(4'd9, 32'hF0, 4'd2, 32'h0, 1'b0, 32'h0, 4'd2, 4'd10, 1'b0);
    #1 check("load_use_in_ready", bus.in_ready, 0);
    step();
    check("bubble_out_valid", bus.out_valid, 0);
    check("bubble_cnt_one",   bus.bubble_cnt, 1);
    bus.mem_rd_addr = 4'd2; bus.mem_rd_we = 1'b1; bus.mem_data = 32'hDEADBEEF;
    #1 check("after_bubble_in_ready", bus.in_ready, 1);
    expect_out(32'hF0, 32'hDEADBEEF, 4'd2, 4'd10, 1'b0);
    step();
    bus.mem_rd_we = 1'b0;

    // Immediate masks the rs2 hazard
    drive(4'd8, 32'h100, 4'd0, 32'h0, 1'b1, 32'h4, 4'd0, 4'd2, 1'b1);
    expect_out(32'h100, 32'h4, 4'd0, 4'd2, 1'b1);
    step();
    drive(4'd3, 32'h30, 4'd2, 32'h99, 1'b1, 32'h10, 4'd0, 4'd11, 1'b0);
    #1 check("imm_no_stall", bus.in_ready, 1);
    expect_out(32'h30, 32'h10, 4'd0, 4'd11, 1'b0);
    step();
    check("imm_bubble_cnt", bus.bubble_cnt, 1);

    // Downstream stall for three cycles
    drive(4'd12, 32'hAAAA, 4'd13, 32'h5555, 1'b0, 32'h0, 4'd4, 4'd12, 1'b0);
    expect_out(32'hAAAA, 32'h5555, 4'd4, 4'd12, 1'b0);
    step();
    bus.out_ready = 1'b0;
    drive(4'd14, 32'h1, 4'd15, 32'h2, 1'b0, 32'h0, 4'd3, 4'd13, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready",  bus.in_ready,  0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_op_a",      bus.op_a,      32'hAAAA);
      check("stall_op_b",      bus.op_b,      32'h5555);
      check("stall_alu_ctrl",  bus.alu_ctrl,  4);
      step();
    end
    check("stall_bubble_cnt", bus.bubble_cnt, 1);
    bus.out_ready = 1'b1;
    expect_out(32'h1, 32'h2, 4'd3, 4'd13, 1'b0);
    step();

    // Flush with load-use and downstream stall pending
    drive(4'd8, 32'h100, 4'd0, 32'h0, 1'b1, 32'h4, 4'd0, 4'd2, 1'b1);
    expect_out(32'h100, 32'h4, 4'd0, 4'd2, 1'b1);
    step();
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    drive(4'd9, 32'hF0, 4'd2, 32'h0, 1'b0, 32'h0, 4'd2, 4'd10, 1'b0);
    #1 check("flush_in_ready", bus.in_ready, 1);
    // The held load is killed by the flush and never reaches downstream.
    void'(exp_q.pop_back());
    step();
    check("flush_out_valid",  bus.out_valid,  0);
    check("flush_bubble_cnt", bus.bubble_cnt, 1);
    check("flush_rd_we",      bus.out_rd_we,  0);
    bus.flush = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    step();
    check("idle_out_valid", bus.out_valid, 0);

    // Reset mid-run with a valid instruction held
    drive(4'd5, 32'h1234, 4'd6, 32'h1, 1'b0, 32'h0, 4'd0, 4'd3, 1'b0);
    bus.out_ready = 1'b0;
    step();
    check("pre_reset_out_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid",  bus.out_valid,  0);
    check("midrst_op_a",       bus.op_a,       0);
    check("midrst_bubble_cnt", bus.bubble_cnt, 0);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step(); step();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
